pe_mac_array: RTL



---
 rtl/pe_mac_array.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_array.sv
// pe_mac_array: dot product of one broadcast activation against N_LANE
// stored weights, reduced by a registered 4:1 adder tree, then biased and
// optionally rectified.
//
//   ofmap = act(bias + sum_k ifmap * weight[k]),  act = ReLU when relu_en
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   wr_en    in   weight write strobe (honoured only while idle)
//   wr_addr  in   weight lane index; indices >= N_LANE are dropped
//   wr_data  in   signed weight value
//   start    in   begin a computation (honoured only while idle)
//   ifmap    in   unsigned activation, sampled with start
//   bias     in   signed bias, sampled with start
//   relu_en  in   ReLU select, sampled with start
//   busy     out  computation in flight
//   done     out  one-cycle completion pulse, coincident with ofmap update
//   ofmap    out  signed result, held until the next completion
//
// Timing: start sampled on edge E0 (products captured there), tree levels
// on E1..EL, bias/ReLU and ofmap on E(L+1); done is therefore visible in
// the (L+2)th cycle counting the start cycle as cycle 0.
module pe_mac_array #(
  parameter int N_LANE = 56,
  parameter int IN_W   = 8,
  parameter int W_W    = 8,
  parameter int ACC_W  = 32,
  localparam int AW    = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W_W-1:0]    wr_data,
  input  logic              start,
  input  logic [IN_W-1:0]   ifmap,
  input  logic [ACC_W-1:0]  bias,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  ofmap
);

  // Number of 4:1 reduction levels, ceil(log4(n)).
  function automatic int clog4(input int n);
    int lvl;
    int cap;
    lvl = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * 4;
      lvl++;
    end
    return lvl;
  endfunction

  localparam int STAGES = clog4(N_LANE);
  localparam int PAD    = 4 ** STAGES;
  localparam int CW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Unsigned activation times signed weight, sign-extended (or wrapped) to ACC_W.
  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic        [IN_W-1:0] a,
    input logic signed [W_W-1:0]  w
  );
    logic signed [IN_W+W_W:0] p;
    p = $signed({1'b0, a}) * w;
    return ACC_W'(p);
  endfunction

  function automatic logic signed [ACC_W-1:0] act_fn(
    input logic signed [ACC_W-1:0] x,
    input logic                    relu
  );
    return (relu && x[ACC_W-1]) ? '0 : x;
  endfunction

  typedef enum logic [1:0] {IDLE, REDUCE, FINAL} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     accept, wr_ok, fin;

  // Lanes N_LANE..PAD-1 are never written, so they feed zeros into the tree.
  logic signed [W_W-1:0]    weight_q [PAD];
  logic signed [ACC_W-1:0]  bias_p0;
  logic                     relu_p0;
  logic signed [ACC_W-1:0]  tree_top;
  logic signed [ACC_W-1:0]  ofmap_q;
  logic                     done_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    wr_ok   = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ok = wr_en;
        if (start) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = (STAGES == 0) ? FINAL : REDUCE;
        end
      end
      REDUCE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STAGES - 1)) state_d = FINAL;
      end
      FINAL: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------- weight store ----------------
  // A write in the start cycle lands on the same edge that captures the
  // products, so that computation still sees the old weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PAD; k++) weight_q[k] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < N_LANE; k++)
        if (wr_addr == AW'(k)) weight_q[k] <= $signed(wr_data);
    end
  end

  // ---------------- stage p0: products, bias and mode capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_p0 <= '0;
      relu_p0 <= 1'b0;
    end else if (accept) begin
      bias_p0 <= $signed(bias);
      relu_p0 <= relu_en;
    end
  end

  // Level 0 holds the products (loaded only on an accepted start); level s
  // sums groups of four from level s-1. Levels above 0 run every cycle,
  // which is harmless because their source is held between starts.
  for (genvar s = 0; s <= STAGES; s++) begin : g_lvl
    localparam int NODES = PAD >> (2 * s);
    logic signed [ACC_W-1:0] sum_p [NODES];

    if (s == 0) begin : g_prod
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < NODES; k++) sum_p[k] <= '0;
        end else if (accept) begin
          for (int k = 0; k < NODES; k++) sum_p[k] <= mul_ext(ifmap, weight_q[k]);
        end
      end
    end else begin : g_sum
      // ---------------- stage p<s>: 4:1 adder level ----------------
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < NODES; j++) sum_p[j] <= '0;
        end else begin
          for (int j = 0; j < NODES; j++)
            sum_p[j] <= g_lvl[s-1].sum_p[4*j]   + g_lvl[s-1].sum_p[4*j+1]
                      + g_lvl[s-1].sum_p[4*j+2] + g_lvl[s-1].sum_p[4*j+3];
        end
      end
    end
  end

  assign tree_top = g_lvl[STAGES].sum_p[0];

  // ---------------- final stage: bias, activation, output ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofmap_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) ofmap_q <= act_fn(tree_top + bias_p0, relu_p0);
    end
  end

  assign done  = done_q;
  assign ofmap = ofmap_q;

endmodule
